main_mips_top: RTL and testbench

//  Top of a tiny single-cycle 16-bit MIPS-like CPU with run/halt/single-step control.
//  A control FSM (instance _fsm) gates a core (instance _mips, datapath instance _main).
//  The datapath holds instruction memory _im.prog[], register file _rf.r[0..3] and data memory _dm.r[].
//  The bench preloads _im.prog by hierarchical assignment and observes state hierarchically.

---
 rtl/main_mips_top.sv | 241 ++++++++++++++++++++++++
 tb/tb_main_mips_top.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/main_mips_top.sv
// main_mips_top: tiny single-cycle 16-bit MIPS-like CPU with run/halt/step control.
//   _fsm  : run/halt/single-step controller, produces the execute enable
//   _mips : core wrapper around the datapath (_main: _im, _rf, _dm)
// Ports:
//   clk      in   clock, all state changes on posedge
//   rst      in   synchronous active-high reset
//   change   in   run/halt toggle request (rising edge acts)
//   step     in   single-step request (rising edge acts, only while halted)
//   pc_out   out  current pc (10 bits)
//   running  out  1 = free-running mode

// Control FSM. Edge detection uses registered copies of change/step; a
// detected edge only alters state/step_pulse, so the edge cycle itself
// executes according to the mode that was already in force.
module mips_fsm (
    input  logic clk,
    input  logic rst,
    input  logic change,
    input  logic step,
    output logic running,
    output logic en
);
    typedef enum logic [1:0] {HALT = 2'b00, RUN = 2'b01} state_t;

    state_t state;
    logic   prev_change, state_step, step_pulse;
    logic   change_rise, step_rise;

    assign change_rise = change & ~prev_change;
    assign step_rise   = step & ~state_step;
    assign en          = running | step_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HALT;
            prev_change <= 1'b0;
            state_step  <= 1'b0;
            step_pulse  <= 1'b0;
            running     <= 1'b0;
        end else begin
            prev_change <= change;
            state_step  <= step;
            // change wins over a same-cycle step edge
            step_pulse  <= (state == HALT) && step_rise && !change_rise;
            if (change_rise) begin
                state   <= (state == HALT) ? RUN : HALT;
                running <= (state == HALT);
            end
        end
    end
endmodule

// Instruction memory. Contents are not reset; the load port lets a
// loader (or the tie-off in the datapath) own the storage.
module mips_im #(
    parameter int DW = 16,
    parameter int IM_DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(IM_DEPTH)-1:0] waddr,
    input  logic [DW-1:0]               wdata,
    input  logic [$clog2(IM_DEPTH)-1:0] addr,
    output logic [DW-1:0]               instr
);
    logic [DW-1:0] prog [IM_DEPTH];

    always_ff @(posedge clk)
        if (we) prog[waddr] <= wdata;

    assign instr = prog[addr];
endmodule

// 4-entry register file, three combinational read ports, one write port.
module mips_rf #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [1:0]    wa,
    input  logic [DW-1:0] wd,
    input  logic [1:0]    ra, rb, rc,
    output logic [DW-1:0] va, vb, vc
);
    logic [DW-1:0] r [4];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r[i] <= '0;
        end else if (we) begin
            r[wa] <= wd;
        end
    end

    assign va = r[ra];
    assign vb = r[rb];
    assign vc = r[rc];
endmodule

// Data memory: combinational read, posedge write.
module mips_dm #(
    parameter int DW = 16,
    parameter int DM_DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [$clog2(DM_DEPTH)-1:0] addr,
    input  logic [DW-1:0]               wd,
    output logic [DW-1:0]               rd
);
    logic [DW-1:0] r [DM_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DM_DEPTH; i++) r[i] <= '0;
        end else if (we) begin
            r[addr] <= wd;
        end
    end

    assign rd = r[addr];
endmodule

// Single-cycle datapath: fetch, decode, execute and write back in one clock.
module mips_datapath #(
    parameter int DW = 16,
    parameter int IM_DEPTH = 64,
    parameter int DM_DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] pc
);
    localparam int IAW = $clog2(IM_DEPTH);
    localparam int DAW = $clog2(DM_DEPTH);

    logic [DW-1:0]  instr, va, vb, vc, dm_rd, rf_wd;
    logic [3:0]     op;
    logic [1:0]     fa, fb, fc;
    logic [5:0]     imm;
    logic [DW-1:0]  simm, zimm;
    logic [DAW-1:0] dm_addr;
    logic           rf_we, dm_we;
    logic [9:0]     pc_nxt;

    assign op   = instr[15:12];
    assign fa   = instr[11:10];
    assign fb   = instr[9:8];
    assign fc   = instr[7:6];
    assign imm  = instr[5:0];
    assign simm = {{(DW-6){imm[5]}}, imm};
    assign zimm = {{(DW-6){1'b0}}, imm};
    // only the low address bits reach memory, so add in that width
    assign dm_addr = vb[DAW-1:0] + simm[DAW-1:0];

    mips_im #(.DW(DW), .IM_DEPTH(IM_DEPTH)) _im (
        .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
        .addr(pc[IAW-1:0]), .instr(instr)
    );

    mips_rf #(.DW(DW)) _rf (
        .clk(clk), .rst(rst), .we(rf_we & en), .wa(fa), .wd(rf_wd),
        .ra(fa), .rb(fb), .rc(fc), .va(va), .vb(vb), .vc(vc)
    );

    mips_dm #(.DW(DW), .DM_DEPTH(DM_DEPTH)) _dm (
        .clk(clk), .rst(rst), .we(dm_we & en), .addr(dm_addr),
        .wd(va), .rd(dm_rd)
    );

    always_comb begin
        rf_we  = 1'b0;
        rf_wd  = '0;
        dm_we  = 1'b0;
        pc_nxt = pc + 10'd1;
        case (op)
            4'b0000: begin
                if (imm == 6'd0) begin
                    rf_we = 1'b1; rf_wd = vb + vc;
                end else if (imm == 6'd1) begin
                    rf_we = 1'b1; rf_wd = vb - vc;
                end
            end
            4'b0001: begin rf_we = 1'b1; rf_wd = vb + simm; end
            4'b0010: begin rf_we = 1'b1; rf_wd = vb + zimm; end
            4'b0011: begin rf_we = 1'b1; rf_wd = dm_rd;     end
            4'b0100: dm_we = 1'b1;
            4'b0101: if (va == vb) pc_nxt = pc + 10'd1 + simm[9:0];
            4'b0110: pc_nxt = instr[9:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)     pc <= '0;
        else if (en) pc <= pc_nxt;
    end
endmodule

// Core wrapper: the gated datapath.
module mips_core #(
    parameter int DW = 16,
    parameter int IM_DEPTH = 64,
    parameter int DM_DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] pc
);
    mips_datapath #(.DW(DW), .IM_DEPTH(IM_DEPTH), .DM_DEPTH(DM_DEPTH)) _main (
        .clk(clk), .rst(rst), .en(en), .pc(pc)
    );
endmodule

module main_mips_top #(
    parameter int DW = 16,
    parameter int IM_DEPTH = 64,
    parameter int DM_DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change,
    input  logic       step,
    output logic [9:0] pc_out,
    output logic       running
);
    logic en;

    mips_fsm _fsm (
        .clk(clk), .rst(rst), .change(change), .step(step),
        .running(running), .en(en)
    );

    mips_core #(.DW(DW), .IM_DEPTH(IM_DEPTH), .DM_DEPTH(DM_DEPTH)) _mips (
        .clk(clk), .rst(rst), .en(en), .pc(pc_out)
    );
endmodule

// File: tb/tb_main_mips_top.sv
// Bench for main_mips_top: directed program from the block description,
// then random programs and random change/step/rst activity, all checked
// every cycle against an instruction-level reference model.
module tb_main_mips_top;
    logic       clk = 1'b0;
    logic       rst = 1'b1, change = 1'b0, step = 1'b0;
    logic [9:0] pc_out;
    logic       running;

    main_mips_top dut (
        .clk(clk), .rst(rst), .change(change), .step(step),
        .pc_out(pc_out), .running(running)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_prog [64];
    int          m_rf [4];
    int          m_dm [64];
    int          m_pc;
    bit          m_run, m_pend, m_lc, m_ls;

    function automatic int sx6(input int v);
        return (v >= 32) ? v - 64 : v;
    endfunction

    task automatic m_exec();
        int i, op, a, b, c, imm, ea;
        i   = int'(m_prog[m_pc % 64]);
        op  = i / 4096;
        a   = (i / 1024) % 4;
        b   = (i / 256) % 4;
        c   = (i / 64) % 4;
        imm = i % 64;
        ea  = ((m_rf[b] + sx6(imm)) % 64 + 64) % 64;
        m_pc = (m_pc + 1) % 1024;
        case (op)
            0: if (imm == 0) m_rf[a] = (m_rf[b] + m_rf[c]) & 16'hFFFF;
               else if (imm == 1) m_rf[a] = (m_rf[b] - m_rf[c]) & 16'hFFFF;
            1: m_rf[a] = (m_rf[b] + sx6(imm)) & 16'hFFFF;
            2: m_rf[a] = (m_rf[b] + imm) & 16'hFFFF;
            3: m_rf[a] = m_dm[ea];
            4: m_dm[ea] = m_rf[a];
            5: if (m_rf[a] == m_rf[b]) m_pc = ((m_pc + sx6(imm)) % 1024 + 1024) % 1024;
            6: m_pc = i % 1024;
            default: ;
        endcase
    endtask

    task automatic m_clock();
        bit cr, sr;
        if (rst) begin
            m_pc = 0; m_run = 0; m_pend = 0; m_lc = 0; m_ls = 0;
            for (int k = 0; k < 4; k++)  m_rf[k] = 0;
            for (int k = 0; k < 64; k++) m_dm[k] = 0;
        end else begin
            if (m_run || m_pend) m_exec();
            cr = change && !m_lc;
            sr = step && !m_ls;
            m_pend = !m_run && sr && !cr;
            if (cr) m_run = !m_run;
            m_lc = change; m_ls = step;
        end
    endtask

    task automatic check_state();
        chk("pc", 32'(pc_out), 32'(m_pc));
        chk("running", 32'(running), 32'(m_run));
        for (int k = 0; k < 4; k++)
            chk($sformatf("r%0d", k), 32'(dut._mips._main._rf.r[k]), 32'(m_rf[k]));
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            m_clock();
            #1;
            check_state();
        end
    endtask

    function automatic logic [15:0] enc_r(input int rd, rs, rt, fn);
        return 16'((rd << 10) | (rs << 8) | (rt << 6) | fn);
    endfunction
    function automatic logic [15:0] enc_i(input int op, a, b, imm);
        return 16'((op << 12) | (a << 10) | (b << 8) | (imm & 63));
    endfunction

    task automatic load(input int idx, input logic [15:0] w);
        m_prog[idx] = w;
        dut._mips._main._im.prog[idx] <= w;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) load(k, 16'hF000);  // NOP filler
        load(0,  enc_i(2, 0, 3, 1));
        load(1,  enc_i(2, 1, 3, 8));
        load(2,  enc_i(2, 2, 3, 2));
        load(3,  enc_r(0, 1, 2, 0));
        load(4,  enc_r(0, 1, 2, 1));
        load(5,  enc_i(4, 0, 2, 0));
        load(6,  enc_i(3, 3, 2, 0));
        load(7,  enc_i(5, 3, 0, 1));
        load(8,  enc_r(0, 1, 1, 0));
        load(9,  enc_r(0, 1, 2, 1));
        load(10, enc_i(1, 0, 2, -1));
        load(11, 16'h6000);

        // reset, then idle with no change edge
        rst = 1'b1; tick(2);
        rst = 1'b0; tick(6);
        chk("idle_pc", 32'(pc_out), 32'd0);
        chk("idle_r0", 32'(dut._mips._main._rf.r[0]), 32'd0);

        // first pass: edge cycle + 11 executed instructions (BEQ skips 8)
        change = 1'b1; tick(12);
        chk("p1_pc", 32'(pc_out), 32'd0);
        chk("p1_r0", 32'(dut._mips._main._rf.r[0]), 32'd1);
        chk("p1_r1", 32'(dut._mips._main._rf.r[1]), 32'd8);
        chk("p1_r2", 32'(dut._mips._main._rf.r[2]), 32'd2);
        chk("p1_r3", 32'(dut._mips._main._rf.r[3]), 32'd6);
        chk("p1_dm2", 32'(dut._mips._main._dm.r[2]), 32'd6);

        // falling edge keeps running; rising edge halts after pc1
        change = 1'b0; tick(1);
        change = 1'b1; tick(11);
        chk("halt_pc", 32'(pc_out), 32'd2);
        chk("halt_run", 32'(running), 32'd0);

        // one step, held high: exactly ADDIU r2=r3+2
        step = 1'b1; tick(5);
        chk("step_pc", 32'(pc_out), 32'd3);
        chk("step_r2", 32'(dut._mips._main._rf.r[2]), 32'd8);

        // resume; step toggling in RUN has no extra effect
        step = 1'b0; change = 1'b0; tick(1);
        change = 1'b1; tick(1);
        for (int k = 0; k < 40; k++) begin
            step = 1'($urandom_range(0, 1)); tick(1);
        end
        chk("run_dm2", 32'(dut._mips._main._dm.r[2]), 32'd6);

        // reset mid-run
        rst = 1'b1; tick(1);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_run", 32'(running), 32'd0);
        chk("rst_r1", 32'(dut._mips._main._rf.r[1]), 32'd0);

        // random programs and control activity
        for (int p = 0; p < 4; p++) begin
            rst = 1'b1; change = 1'b0; step = 1'b0;
            for (int k = 0; k < 64; k++) begin
                int op;
                op = $urandom_range(0, 9);
                if (op == 0) load(k, enc_r($urandom_range(0,3), $urandom_range(0,3),
                                           $urandom_range(0,3), $urandom_range(0,2)));
                else if (op == 6) load(k, 16'(16'h6000 | $urandom_range(0, 1023)));
                else load(k, enc_i(op, $urandom_range(0,3), $urandom_range(0,3),
                                   $urandom_range(0,63)));
            end
            tick(1);
            rst = 1'b0;
            for (int k = 0; k < 700; k++) begin
                if ($urandom_range(0, 15) == 0) change = ~change;
                if ($urandom_range(0, 3) == 0)  step = ~step;
                rst = ($urandom_range(0, 199) == 0);
                tick(1);
            end
            for (int k = 0; k < 64; k++)
                chk($sformatf("dm%0d", k), 32'(dut._mips._main._dm.r[k]), 32'(m_dm[k]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
